// File: rtl/spi_minion_multimode.sv
// SPI minion for all four CPOL/CPHA modes with NBITS-wide words, multi-word frames, an RX FIFO and a TX pull handshake.
// Build option: define SPI_MINION_FRAME_CNT_EN to add o_frame_words (complete words seen in the most recent frame).
module spi_minion_multimode #(
  parameter int NBITS = 8,
  parameter int DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cs,
  input  logic             i_sclk,
  input  logic             i_mosi,
  output logic             o_miso,
  input  logic             i_cpol,
  input  logic             i_cpha,
  output logic [NBITS-1:0] o_recv_msg,
  output logic             o_recv_val,
  input  logic             i_recv_rdy,
  input  logic [NBITS-1:0] i_send_msg,
  input  logic             i_send_val,
  output logic             o_send_rdy,
  output logic             o_overflow,
  output logic             o_underflow,
  input  logic             i_clr_flags,
  output logic             o_busy
`ifdef SPI_MINION_FRAME_CNT_EN
  ,
  output logic [15:0]      o_frame_words
`endif
);

  localparam int CW = $clog2(NBITS);
  localparam int AW = $clog2(DEPTH);

  logic [2:0]       r_cs_sync;
  logic [2:0]       r_sclk_sync;
  logic [1:0]       r_mosi_sync;
  logic             r_post;
  logic             r_armed;
  logic             r_active;
  logic             r_cpol;
  logic             r_cpha;
  logic [CW-1:0]    r_bit_cnt;
  logic [NBITS-1:0] r_rx_shreg;
  logic [NBITS-1:0] r_tx_shreg;
  logic [NBITS-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_send_rdy;
  logic             r_overflow;
  logic             r_underflow;
`ifdef SPI_MINION_FRAME_CNT_EN
  logic [15:0]      r_word_cnt;
  logic [15:0]      r_frame_words;
`endif

  logic             w_cs_fall, w_cs_rise, w_sclk_rise, w_sclk_fall;
  logic             w_start, w_end, w_lead, w_trail, w_sample, w_txedge;
  logic             w_last, w_word_done, w_load, w_shift;
  logic             w_full, w_pop, w_push;
  logic [NBITS-1:0] w_rx_word;

  assign w_cs_fall   = r_cs_sync[2] & ~r_cs_sync[1];
  assign w_cs_rise   = ~r_cs_sync[2] & r_cs_sync[1];
  assign w_sclk_rise = ~r_sclk_sync[2] & r_sclk_sync[1];
  assign w_sclk_fall = r_sclk_sync[2] & ~r_sclk_sync[1];

  // A frame only starts from a cs fall seen after cs was observed high since reset.
  assign w_start     = w_cs_fall & r_armed;
  assign w_end       = w_cs_rise & r_active;
  assign w_lead      = r_active & (r_cpol ? w_sclk_fall : w_sclk_rise);
  assign w_trail     = r_active & (r_cpol ? w_sclk_rise : w_sclk_fall);
  assign w_sample    = r_cpha ? w_trail : w_lead;
  assign w_txedge    = r_cpha ? w_lead : w_trail;
  assign w_last      = (r_bit_cnt == CW'(NBITS - 1));
  assign w_word_done = w_sample & w_last;
  assign w_rx_word   = {r_rx_shreg[NBITS-2:0], r_mosi_sync[1]};

  // Bit counter at zero on a TX edge means a fresh word begins: load instead of shift.
  assign w_load      = (w_start & ~i_cpha) | (w_txedge & (r_bit_cnt == '0));
  assign w_shift     = w_txedge & (r_bit_cnt != '0);

  assign w_full      = (r_count == (AW+1)'(DEPTH));
  assign w_pop       = o_recv_val & i_recv_rdy;
  assign w_push      = w_word_done & (~w_full | w_pop);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_cs_sync   <= 3'b111;
      r_sclk_sync <= 3'b000;
      r_mosi_sync <= 2'b00;
      r_post      <= 1'b0;
      r_armed     <= 1'b0;
      r_active    <= 1'b0;
      r_cpol      <= 1'b0;
      r_cpha      <= 1'b0;
      r_bit_cnt   <= '0;
      r_rx_shreg  <= '0;
      r_tx_shreg  <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_send_rdy  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
`ifdef SPI_MINION_FRAME_CNT_EN
      r_word_cnt    <= '0;
      r_frame_words <= '0;
`endif
    end else begin
      r_cs_sync   <= {r_cs_sync[1:0], i_cs};
      r_sclk_sync <= {r_sclk_sync[1:0], i_sclk};
      r_mosi_sync <= {r_mosi_sync[0], i_mosi};
      r_post      <= 1'b1;
      r_armed     <= r_armed | (r_post & r_cs_sync[0]);

      if (w_start) begin
        r_active <= 1'b1;
        r_cpol   <= i_cpol;
        r_cpha   <= i_cpha;
      end else if (w_cs_rise) begin
        r_active <= 1'b0;
      end

      if (w_start || w_end)
        r_bit_cnt <= '0;
      else if (w_sample)
        r_bit_cnt <= w_last ? '0 : r_bit_cnt + 1'b1;

      if (w_sample)
        r_rx_shreg <= w_rx_word;

      if (w_load)
        r_tx_shreg <= i_send_val ? i_send_msg : '0;
      else if (w_shift)
        r_tx_shreg <= {r_tx_shreg[NBITS-2:0], 1'b0};

      r_send_rdy <= w_load;

      if (w_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};

      r_overflow  <= (w_word_done & w_full & ~w_pop) | (r_overflow & ~i_clr_flags);
      r_underflow <= (w_load & ~i_send_val) | (r_underflow & ~i_clr_flags);

`ifdef SPI_MINION_FRAME_CNT_EN
      if (w_start)
        r_word_cnt <= '0;
      else if (w_word_done && r_word_cnt != 16'hFFFF)
        r_word_cnt <= r_word_cnt + 16'd1;
      if (w_end)
        r_frame_words <= r_word_cnt;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= w_rx_word;
  end

  assign o_recv_val  = (r_count != '0);
  assign o_recv_msg  = o_recv_val ? r_mem[r_rd_ptr] : '0;
  assign o_miso      = r_active & r_tx_shreg[NBITS-1];
  assign o_busy      = r_active;
  assign o_send_rdy  = r_send_rdy;
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;
`ifdef SPI_MINION_FRAME_CNT_EN
  assign o_frame_words = r_frame_words;
`endif

endmodule

// File: tb/tb_spi_minion_multimode.sv
// Randomised bench for spi_minion_multimode: an SPI master model drives frames and compares
// received words, miso words, pull strobes and flags against expectations from the protocol rules.
module tb_spi_minion_multimode;
  localparam int NBITS = 8;
  localparam int DEPTH = 2;
  localparam int H     = 6;

  logic             clk = 1'b0;
  logic             i_reset, i_cs, i_sclk, i_mosi, i_cpol, i_cpha;
  logic             i_recv_rdy, i_send_val, i_clr_flags;
  logic [NBITS-1:0] i_send_msg;
  logic             o_miso, o_recv_val, o_send_rdy, o_overflow, o_underflow, o_busy;
  logic [NBITS-1:0] o_recv_msg;
`ifdef SPI_MINION_FRAME_CNT_EN
  logic [15:0]      o_frame_words;
`endif

  always #5 clk = ~clk;

  spi_minion_multimode #(.NBITS(NBITS), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_cs(i_cs), .i_sclk(i_sclk), .i_mosi(i_mosi),
    .o_miso(o_miso), .i_cpol(i_cpol), .i_cpha(i_cpha),
    .o_recv_msg(o_recv_msg), .o_recv_val(o_recv_val), .i_recv_rdy(i_recv_rdy),
    .i_send_msg(i_send_msg), .i_send_val(i_send_val), .o_send_rdy(o_send_rdy),
    .o_overflow(o_overflow), .o_underflow(o_underflow), .i_clr_flags(i_clr_flags),
    .o_busy(o_busy)
`ifdef SPI_MINION_FRAME_CNT_EN
    , .o_frame_words(o_frame_words)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // TX words offered by the application side; one is consumed per send_rdy strobe.
  logic [NBITS-1:0] tx_words [16];
  logic [NBITS-1:0] mw [16];
  logic [NBITS-1:0] got [16];
  logic [NBITS-1:0] pop_mem [256];
  int               rdy_total = 0;
  int               rdy_base = 0;
  int               pop_cnt = 0;
  logic [3:0]       tx_sel;

  assign tx_sel     = 4'(rdy_total - rdy_base);
  assign i_send_msg = tx_words[tx_sel];

  always @(negedge clk) begin
    if (o_send_rdy) rdy_total++;
    if (o_recv_val && i_recv_rdy) begin
      pop_mem[pop_cnt % 256] = o_recv_msg;
      pop_cnt++;
    end
  end

  task automatic set_rdy(input logic v);
    @(posedge clk);
    #1 i_recv_rdy = v;
  endtask

  // Master: clocks nbits bits of mw[] in the given mode; rst_bit >= 0 pulses reset before that bit.
  task automatic frame(input bit pol, input bit pha, input int nbits, input int rst_bit);
    @(negedge clk);
    i_cpol = pol; i_cpha = pha; i_sclk = pol;
    repeat (8) @(negedge clk);
    rdy_base = rdy_total;
    for (int k = 0; k < 16; k++) got[k] = '0;
    i_cs = 1'b0;
    if (!pha) i_mosi = mw[0][NBITS-1];
    repeat (2*H) @(negedge clk);
    for (int b = 0; b < nbits; b++) begin
      int w  = b / NBITS;
      int bi = NBITS - 1 - (b % NBITS);
      if (b == 0 && rst_bit < 0) begin
        check_val("busy_in_frame", 32'(o_busy), 32'd1);
        check_val("load_at_start", 32'(rdy_total - rdy_base), pha ? 32'd0 : 32'd1);
      end
      if (b == rst_bit) begin
        i_reset = 1'b0;
        @(negedge clk);
        i_reset = 1'b1;
        check_val("rst_busy", 32'(o_busy), 32'd0);
        check_val("rst_miso", 32'(o_miso), 32'd0);
        check_val("rst_recv_val", 32'(o_recv_val), 32'd0);
        check_val("rst_recv_msg", 32'(o_recv_msg), 32'd0);
        check_val("rst_send_rdy", 32'(o_send_rdy), 32'd0);
        check_val("rst_overflow", 32'(o_overflow), 32'd0);
        check_val("rst_underflow", 32'(o_underflow), 32'd0);
      end
      i_sclk = ~pol;
      if (pha) i_mosi = mw[w][bi];
      else     got[w][bi] = o_miso;
      repeat (H) @(negedge clk);
      i_sclk = pol;
      if (pha) got[w][bi] = o_miso;
      else if (b + 1 < nbits) i_mosi = mw[(b+1)/NBITS][NBITS-1-((b+1)%NBITS)];
      repeat (H) @(negedge clk);
    end
    i_cs = 1'b1;
    repeat (2*H) @(negedge clk);
    $display("frame cpol=%0d cpha=%0d bits=%0d rst_bit=%0d w0=%0h miso0=%0h", pol, pha, nbits, rst_bit, mw[0], got[0]);
  endtask

  // Expected miso words and pull count follow the load rules: cpha=0 loads at start and after each word.
  task automatic check_tx(input bit pha, input int nw, input bit sv);
    for (int k = 0; k < nw; k++)
      check_val("miso_word", 32'(got[k]), sv ? 32'(tx_words[k]) : 32'd0);
    check_val("send_rdy_count", 32'(rdy_total - rdy_base), pha ? 32'(nw) : 32'(nw + 1));
`ifdef SPI_MINION_FRAME_CNT_EN
    check_val("frame_words", 32'(o_frame_words), 32'(nw));
`endif
  endtask

  task automatic check_rx(input int base, input int nw);
    check_val("rx_count", 32'(pop_cnt - base), 32'(nw));
    for (int k = 0; k < nw; k++)
      check_val("rx_word", 32'(pop_mem[(base + k) % 256]), 32'(mw[k]));
  endtask

  task automatic fill_tx(input logic [NBITS-1:0] v, input bit rnd);
    for (int k = 0; k < 16; k++) tx_words[k] = rnd ? NBITS'($urandom) : v;
  endtask

  initial begin
    int base;
    logic [NBITS-1:0] ref_q [$];
    bit ovf_exp;
    bit p, q;
    int nw;

    i_reset = 1'b0; i_cs = 1'b1; i_sclk = 1'b0; i_mosi = 1'b0;
    i_cpol = 1'b0; i_cpha = 1'b0; i_recv_rdy = 1'b1; i_send_val = 1'b1; i_clr_flags = 1'b0;
    fill_tx('0, 1'b0);
    repeat (3) @(negedge clk);
    check_val("reset_recv_val", 32'(o_recv_val), 32'd0);
    check_val("reset_miso", 32'(o_miso), 32'd0);
    check_val("reset_busy", 32'(o_busy), 32'd0);
    check_val("reset_send_rdy", 32'(o_send_rdy), 32'd0);
    check_val("reset_flags", {30'd0, o_overflow, o_underflow}, 32'd0);
    i_reset = 1'b1;
    repeat (5) @(negedge clk);

    // Mode 0 single word, consumer stalled so the head can be inspected.
    fill_tx(8'hA5, 1'b0);
    mw[0] = 8'h3C;
    set_rdy(1'b0);
    base = pop_cnt;
    frame(1'b0, 1'b0, NBITS, -1);
    check_tx(1'b0, 1, 1'b1);
    check_val("m0_recv_val", 32'(o_recv_val), 32'd1);
    check_val("m0_recv_msg", 32'(o_recv_msg), 32'h3C);
    set_rdy(1'b1);
    repeat (4) @(negedge clk);
    check_rx(base, 1);
    check_val("m0_drained", 32'(o_recv_val), 32'd0);

    // Modes 1..3.
    for (int m = 1; m < 4; m++) begin
      fill_tx(8'h96, 1'b0);
      mw[0] = 8'h5A;
      base = pop_cnt;
      frame(m[1], m[0], NBITS, -1);
      check_tx(m[0], 1, 1'b1);
      check_rx(base, 1);
    end

    // Three words into a stalled two-entry FIFO.
    mw[0] = 8'h11; mw[1] = 8'h22; mw[2] = 8'h33;
    fill_tx('0, 1'b1);
    ref_q = {};
    ovf_exp = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (ref_q.size() < DEPTH) ref_q.push_back(mw[k]);
      else ovf_exp = 1'b1;
    end
    set_rdy(1'b0);
    base = pop_cnt;
    frame(1'b0, 1'b0, 3*NBITS, -1);
    check_tx(1'b0, 3, 1'b1);
    check_val("ovf_flag", 32'(o_overflow), 32'(ovf_exp));
    check_val("ovf_head", 32'(o_recv_msg), 32'(ref_q[0]));
    check_val("ovf_underflow", 32'(o_underflow), 32'd0);
    set_rdy(1'b1);
    repeat (6) @(negedge clk);
    check_val("ovf_pops", 32'(pop_cnt - base), 32'(ref_q.size()));
    for (int k = 0; k < ref_q.size(); k++)
      check_val("ovf_pop_word", 32'(pop_mem[(base + k) % 256]), 32'(ref_q[k]));
    check_val("ovf_drained", 32'(o_recv_val), 32'd0);
    i_clr_flags = 1'b1;
    @(negedge clk);
    i_clr_flags = 1'b0;
    check_val("ovf_cleared", 32'(o_overflow), 32'd0);

    // No TX data offered.
    i_send_val = 1'b0;
    fill_tx('0, 1'b1);
    mw[0] = NBITS'($urandom); mw[1] = NBITS'($urandom);
    p = 1'($urandom); q = 1'($urandom);
    base = pop_cnt;
    frame(p, q, 2*NBITS, -1);
    check_tx(q, 2, 1'b0);
    check_rx(base, 2);
    check_val("underflow_set", 32'(o_underflow), 32'd1);
    i_send_val = 1'b1;

    // Partial word then a clean frame.
    mw[0] = NBITS'($urandom);
    base = pop_cnt;
    frame(p, q, 5, -1);
    check_val("partial_no_push", 32'(pop_cnt - base), 32'd0);
    check_val("partial_recv_val", 32'(o_recv_val), 32'd0);
    mw[0] = 8'hF0;
    fill_tx('0, 1'b1);
    base = pop_cnt;
    frame(p, q, NBITS, -1);
    check_tx(q, 1, 1'b1);
    check_rx(base, 1);

    // Reset pulse mid-frame; underflow is still set from above so its clearing is visible.
    mw[0] = NBITS'($urandom);
    base = pop_cnt;
    frame(1'b0, 1'b0, NBITS, 4);
    check_val("rst_no_push", 32'(pop_cnt - base), 32'd0);
    check_val("rst_after_busy", 32'(o_busy), 32'd0);
    mw[0] = 8'h81;
    fill_tx('0, 1'b1);
    base = pop_cnt;
    frame(1'b0, 1'b0, NBITS, -1);
    check_tx(1'b0, 1, 1'b1);
    check_rx(base, 1);

    // Random frames.
    for (int r = 0; r < 20; r++) begin
      p = 1'($urandom); q = 1'($urandom);
      nw = $urandom_range(1, 3);
      fill_tx('0, 1'b1);
      for (int k = 0; k < 16; k++) mw[k] = NBITS'($urandom);
      base = pop_cnt;
      frame(p, q, nw*NBITS, -1);
      check_tx(q, nw, 1'b1);
      check_rx(base, nw);
    end
    check_val("final_overflow", 32'(o_overflow), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
